// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC result serializer.
// Holds field widths, frame length and the packed {phase, mag} result.
package cordic_pkg;

   localparam int MAG_W            = 16;
   localparam int PHASE_W          = 32;
   localparam int BYTES_PER_RESULT = 6;
   localparam int RESULT_W         = MAG_W + PHASE_W;

   typedef struct packed {
      logic [PHASE_W-1:0] phase;
      logic [MAG_W-1:0]   mag;
   } result_t;

   // Frame order: mag low/high, then phase from LSB to MSB.
   function automatic logic [7:0] result_byte(
      input result_t    r,
      input logic [2:0] i
   );
      logic [7:0] b;
      b = 8'h00;
      case (i)
         3'd0:    b = r.mag[7:0];
         3'd1:    b = r.mag[15:8];
         3'd2:    b = r.phase[7:0];
         3'd3:    b = r.phase[15:8];
         3'd4:    b = r.phase[23:16];
         3'd5:    b = r.phase[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// Small result FIFO (DEPTH 2 or 4) with occupancy count.
// Ports: clk, rst, push/wdata, pop/rdata, full, empty, level.
module cordic_result_fifo
   import cordic_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  result_t    wdata,
   input  logic       pop,
   output result_t    rdata,
   output logic       full,
   output logic       empty,
   output logic [2:0] level
);

   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam logic [2:0]    DEPTH_L = 3'(DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

   result_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [2:0]    count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == DEPTH_L);
   assign empty   = (count == 3'd0);
   assign level   = count;
   assign rdata   = mem[rd_ptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   function automatic logic [PW-1:0] next_ptr(
      input logic [PW-1:0] p
   );
      return (p == LAST_P) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 3'd0;
      end else begin
         if (push_ok)
            wr_ptr <= next_ptr(wr_ptr);
         if (pop_ok)
            rd_ptr <= next_ptr(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cordic_result_serializer.sv
// Serializes {phase, mag} CORDIC results into 6-byte frames.
// Ports: res_* result handshake in, out_* byte stream out, level.
module cordic_result_serializer
   import cordic_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic [15:0] res_mag,
   input  logic [31:0] res_phase,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic [2:0]  level
);

   localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_RESULT - 1);

   result_t    wdata;
   result_t    head;
   logic       full;
   logic       empty;
   logic       push;
   logic       pop;
   logic       xfer;
   logic [2:0] idx;

   assign wdata.phase = res_phase;
   assign wdata.mag   = res_mag;

   // Ready comes only from registered occupancy.
   assign res_ready = !full;
   assign out_valid = !empty;
   assign out_last  = out_valid && (idx == LAST_IDX);
   assign out_byte  = out_valid ? result_byte(head, idx) : 8'h00;

   assign push = res_valid && res_ready;
   assign xfer = out_valid && out_ready;
   assign pop  = xfer && (idx == LAST_IDX);

   cordic_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (rst)
         idx <= 3'd0;
      else if (xfer)
         idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
   end

endmodule

// File: tb/tb_cordic_result_serializer.sv
// Scoreboard bench: accepted results expand into expected bytes,
// a negedge monitor compares the byte stream and handshake outputs.
module tb_cordic_result_serializer;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_mag;
   logic [31:0] res_phase;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [2:0]  level;

   int n_checks = 0;
   int n_fail   = 0;

   byte unsigned exp_q[$];
   bit           accept_flag = 0;

   cordic_result_serializer #(
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_mag   (res_mag),
      .res_phase (res_phase),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .level     (level)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  name, $time, act, exp);
      end
   endtask

   // Monitor: compare against model, then retire the byte if taken.
   always @(negedge clk) begin
      int sz;
      int lvl;
      bit vld;
      sz  = exp_q.size();
      lvl = (sz + 5) / 6;
      vld = (sz != 0);
      check("level", 32'(level), 32'(lvl));
      check("res_ready", 32'(res_ready), 32'(lvl != DEPTH));
      check("out_valid", 32'(out_valid), 32'(vld));
      check("out_byte", 32'(out_byte),
            vld ? 32'(exp_q[0]) : 32'h0);
      check("out_last", 32'(out_last),
            32'(vld && (sz % 6 == 1)));
      accept_flag = res_valid && (lvl != DEPTH) && !rst;
      if (vld && out_ready && !rst)
         void'(exp_q.pop_front());
   end

   // Stimulus side: an accepted result becomes six expected bytes.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else if (accept_flag) begin
         exp_q.push_back(res_mag[7:0]);
         exp_q.push_back(res_mag[15:8]);
         exp_q.push_back(res_phase[7:0]);
         exp_q.push_back(res_phase[15:8]);
         exp_q.push_back(res_phase[23:16]);
         exp_q.push_back(res_phase[31:24]);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [15:0] m,
                           input logic [31:0] p);
      int t;
      res_mag   = m;
      res_phase = p;
      res_valid = 1;
      t = 0;
      do begin
         @(posedge clk);
         t++;
      end while (!accept_flag && t < 60);
      #1;
      res_valid = 0;
      n_checks++;
      if (t >= 60) begin
         n_fail++;
         $display("FAIL push_timeout mag=%0h", m);
      end
   endtask

   task automatic drain(input int budget);
      int t;
      out_ready = 1;
      t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         cyc(1);
         t++;
      end
      cyc(2);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout left=%0d need=0",
                  exp_q.size());
      end
   endtask

   initial begin
      rst       = 1;
      res_valid = 0;
      res_mag   = 0;
      res_phase = 0;
      out_ready = 0;
      cyc(2);
      rst = 0;
      cyc(2);

      // Single frame, host always ready.
      out_ready = 1;
      push_one(16'h61A8, 32'h12345678);
      drain(20);

      // Stalled host: one ready pulse every 4 cycles.
      out_ready = 0;
      push_one(16'h61A8, 32'h12345678);
      for (int i = 0; i < 6; i++) begin
         cyc(3);
         out_ready = 1;
         cyc(1);
         out_ready = 0;
      end
      drain(20);

      // Fill to DEPTH, third result refused, then back-to-back.
      out_ready = 0;
      push_one(16'h0001, 32'h00000002);
      push_one(16'h0003, 32'h00000004);
      res_mag   = 16'h0005;
      res_phase = 32'h00000006;
      res_valid = 1;
      cyc(3);
      res_valid = 0;
      out_ready = 1;
      drain(20);

      // Push lands on the same edge as byte 5 of the head.
      out_ready = 0;
      push_one(16'hAAAA, 32'hBBBBCCCC);
      out_ready = 1;
      cyc(5);
      res_mag   = 16'h1357;
      res_phase = 32'h2468ACE0;
      res_valid = 1;
      cyc(1);
      res_valid = 0;
      drain(20);

      // Reset after byte 2 of a frame.
      out_ready = 0;
      push_one(16'h61A8, 32'h12345678);
      out_ready = 1;
      cyc(3);
      rst = 1;
      cyc(1);
      rst = 0;
      cyc(2);
      push_one(16'h61A8, 32'h12345678);
      drain(20);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         res_valid = 1'($urandom_range(0, 1));
         res_mag   = 16'($urandom);
         res_phase = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         cyc(1);
      end
      res_valid = 0;
      drain(100);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
